// File: rtl/rr_arbiter16_pkg.sv
// Shared types and helpers for the 16-requester round-robin arbiter.
package arb16_pkg;
    localparam int REQ_W = 16;
    localparam int IDX_W = 4;

    typedef enum logic {IDLE, GRANT} arb_state_t;
    typedef logic [REQ_W-1:0] req_vec_t;
    typedef logic [IDX_W-1:0] idx_t;

    function automatic req_vec_t idx_to_onehot(input idx_t idx);
        return req_vec_t'(1) << idx;
    endfunction

    // Bits strictly below idx; idx=0 yields an empty mask.
    function automatic req_vec_t below_mask(input idx_t idx);
        return (req_vec_t'(1) << idx) - req_vec_t'(1);
    endfunction
endpackage

// File: rtl/rr_arbiter16_if.sv
// Requester-bank side of the arbiter: request/release in, registered grant out.
interface rr_arbiter16_if;
    import arb16_pkg::*;

    req_vec_t   Req;
    logic       Done;
    req_vec_t   Gnt;
    idx_t       GntIdx;
    logic       GntValid;
    logic       Preempt;

    modport master (
        output Req,
        output Done,
        input  Gnt,
        input  GntIdx,
        input  GntValid,
        input  Preempt
    );

    modport slave (
        input  Req,
        input  Done,
        output Gnt,
        output GntIdx,
        output GntValid,
        output Preempt
    );
endinterface

// File: rtl/rr_arbiter16_penc.sv
// 16:4 MSB-first priority encoder; returns 0 when disabled or no bit is set.
module rr_arbiter16_penc
    import arb16_pkg::*;
(
    input  logic     i_en,
    input  req_vec_t i_req,
    output idx_t     o_idx
);

    // Ascending scan, so the highest set bit is the last assignment and wins.
    always_comb begin
        o_idx = '0;
        if (i_en) begin
            for (int i = 0; i < REQ_W; i++) begin
                if (i_req[i]) begin
                    o_idx = idx_t'(i);
                end
            end
        end
    end

endmodule

// File: rtl/rr_arbiter16.sv
// 16-requester arbiter with rotating priority, registered one-hot grant and
// a hold timeout that hands the resource on when others are waiting.
module rr_arbiter16
    import arb16_pkg::*;
#(
    parameter int HOLD_MAX   = 16,
    parameter bit FIXED_PRIO = 1'b0
)
(
    input  logic          clk,
    input  logic          rst,
    rr_arbiter16_if.slave bus
);

    localparam int CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_t       r_state;
    req_vec_t         r_gnt;
    idx_t             r_gntIdx;
    logic             r_gntValid;
    logic             r_preempt;
    logic [CNT_W-1:0] r_holdCnt;
    idx_t             r_lastIdx;

    arb_state_t       w_nextState;
    req_vec_t         w_nextGnt;
    idx_t             w_nextGntIdx;
    logic             w_nextGntValid;
    logic             w_nextPreempt;
    logic [CNT_W-1:0] w_nextHoldCnt;
    idx_t             w_nextLastIdx;

    logic             w_ownerReq;
    logic             w_release;
    logic             w_others;
    logic             w_holdExpired;
    idx_t             w_maskIdx;
    req_vec_t         w_exclude;
    req_vec_t         w_cand;
    req_vec_t         w_candMasked;
    logic             w_maskedZero;
    idx_t             w_idxMasked;
    idx_t             w_idxFull;
    idx_t             w_pickIdx;

    assign w_ownerReq    = |(bus.Req & r_gnt);
    assign w_release     = bus.Done | ~w_ownerReq;
    assign w_others      = |(bus.Req & ~r_gnt);
    assign w_holdExpired = (r_holdCnt == CNT_LAST);

    // While a grant is held the rotation pivots on the owner; on a timeout the
    // owner is removed from the candidates so it has to re-win later.
    assign w_maskIdx    = (r_state == GRANT) ? r_gntIdx : r_lastIdx;
    assign w_exclude    = ((r_state == GRANT) && !w_release) ? r_gnt : '0;
    assign w_cand       = bus.Req & ~w_exclude;
    assign w_candMasked = w_cand & below_mask(w_maskIdx);
    assign w_maskedZero = ~|w_candMasked;

    rr_arbiter16_penc u_encMasked (
        .i_en  (1'b1),
        .i_req (w_candMasked),
        .o_idx (w_idxMasked)
    );

    rr_arbiter16_penc u_encFull (
        .i_en  (1'b1),
        .i_req (w_cand),
        .o_idx (w_idxFull)
    );

    assign w_pickIdx = (FIXED_PRIO || w_maskedZero) ? w_idxFull : w_idxMasked;

    always_comb begin
        w_nextState    = r_state;
        w_nextGnt      = r_gnt;
        w_nextGntIdx   = r_gntIdx;
        w_nextGntValid = r_gntValid;
        w_nextPreempt  = 1'b0;
        w_nextHoldCnt  = r_holdCnt;
        w_nextLastIdx  = r_lastIdx;

        case (r_state)
            IDLE: begin
                if (|bus.Req) begin
                    w_nextState    = GRANT;
                    w_nextGnt      = idx_to_onehot(w_pickIdx);
                    w_nextGntIdx   = w_pickIdx;
                    w_nextGntValid = 1'b1;
                    w_nextHoldCnt  = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_nextLastIdx = r_gntIdx;
                    w_nextHoldCnt = '0;
                    if (w_others) begin
                        w_nextGnt    = idx_to_onehot(w_pickIdx);
                        w_nextGntIdx = w_pickIdx;
                    end else begin
                        w_nextState    = IDLE;
                        w_nextGnt      = '0;
                        w_nextGntValid = 1'b0;
                    end
                end else if (w_holdExpired) begin
                    w_nextHoldCnt = '0;
                    if (w_others) begin
                        w_nextPreempt = 1'b1;
                        w_nextLastIdx = r_gntIdx;
                        w_nextGnt     = idx_to_onehot(w_pickIdx);
                        w_nextGntIdx  = w_pickIdx;
                    end
                end else begin
                    w_nextHoldCnt = r_holdCnt + CNT_W'(1);
                end
            end
            default: begin
                w_nextState    = IDLE;
                w_nextGnt      = '0;
                w_nextGntValid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gntIdx   <= '0;
            r_gntValid <= 1'b0;
            r_preempt  <= 1'b0;
            r_holdCnt  <= '0;
            r_lastIdx  <= idx_t'(REQ_W - 1);
        end else begin
            r_state    <= w_nextState;
            r_gnt      <= w_nextGnt;
            r_gntIdx   <= w_nextGntIdx;
            r_gntValid <= w_nextGntValid;
            r_preempt  <= w_nextPreempt;
            r_holdCnt  <= w_nextHoldCnt;
            r_lastIdx  <= w_nextLastIdx;
        end
    end

    assign bus.Gnt      = r_gnt;
    assign bus.GntIdx   = r_gntIdx;
    assign bus.GntValid = r_gntValid;
    assign bus.Preempt  = r_preempt;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16: one round-robin and one fixed-priority instance.
module tb_rr_arbiter16;
    import arb16_pkg::*;

    typedef struct {
        req_vec_t req;
        logic     done;
        req_vec_t expGnt;
        idx_t     expIdx;
        logic     expValid;
        logic     expPre;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails = 0;

    vec_t tbl1[9];
    vec_t tbl2[17];

    always #5 clk = ~clk;

    rr_arbiter16_if busRr();
    rr_arbiter16_if busFix();

    rr_arbiter16 #(.HOLD_MAX(16), .FIXED_PRIO(1'b0)) dutRr (
        .clk (clk),
        .rst (rst),
        .bus (busRr)
    );

    rr_arbiter16 #(.HOLD_MAX(16), .FIXED_PRIO(1'b1)) dutFix (
        .clk (clk),
        .rst (rst),
        .bus (busFix)
    );

    task automatic checkOutput(input string name,
                               input req_vec_t actGnt, input idx_t actIdx,
                               input logic actValid, input logic actPre,
                               input req_vec_t expGnt, input idx_t expIdx,
                               input logic expValid, input logic expPre);
        checks++;
        if (actGnt !== expGnt || actIdx !== expIdx || actValid !== expValid || actPre !== expPre) begin
            fails++;
            $display("[TB] FAIL %s: got gnt=%h idx=%0d valid=%b preempt=%b, expected gnt=%h idx=%0d valid=%b preempt=%b",
                     name, actGnt, actIdx, actValid, actPre, expGnt, expIdx, expValid, expPre);
        end
    endtask

    task automatic checkRr(input string name, input req_vec_t g, input idx_t i,
                           input logic v, input logic p);
        checkOutput(name, busRr.Gnt, busRr.GntIdx, busRr.GntValid, busRr.Preempt, g, i, v, p);
    endtask

    task automatic checkFix(input string name, input req_vec_t g, input idx_t i,
                            input logic v, input logic p);
        checkOutput(name, busFix.Gnt, busFix.GntIdx, busFix.GntValid, busFix.Preempt, g, i, v, p);
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input bit toFix, input req_vec_t req, input logic done);
        @(negedge clk);
        if (toFix) begin
            busFix.Req  = req;
            busFix.Done = done;
        end else begin
            busRr.Req  = req;
            busRr.Done = done;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        busRr.Req   = '0;
        busRr.Done  = 1'b0;
        busFix.Req  = '0;
        busFix.Done = 1'b0;

        tbl1[0] = '{16'h0001, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0};
        tbl1[1] = '{16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0};
        tbl1[2] = '{16'h8001, 1'b0, 16'h8000, 4'd15, 1'b1, 1'b0};
        tbl1[3] = '{16'h8001, 1'b1, 16'h0001, 4'd0,  1'b1, 1'b0};
        tbl1[4] = '{16'h8001, 1'b1, 16'h8000, 4'd15, 1'b1, 1'b0};
        tbl1[5] = '{16'h8001, 1'b1, 16'h0001, 4'd0,  1'b1, 1'b0};
        tbl1[6] = '{16'h8001, 1'b1, 16'h8000, 4'd15, 1'b1, 1'b0};
        tbl1[7] = '{16'h0000, 1'b0, 16'h0000, 4'd15, 1'b0, 1'b0};
        tbl1[8] = '{16'h0000, 1'b1, 16'h0000, 4'd15, 1'b0, 1'b0};

        // Full load with Done every cycle after reset: 14 down to 0, then 15, 14.
        for (int k = 0; k < 17; k++) begin
            idx_t e;
            e = (k <= 14) ? idx_t'(14 - k) : ((k == 15) ? 4'd15 : 4'd14);
            tbl2[k] = '{16'hFFFF, 1'b1, req_vec_t'(1) << e, e, 1'b1, 1'b0};
        end

        #12;
        checkRr("reset_rr", 16'h0000, 4'd0, 1'b0, 1'b0);
        checkFix("reset_fix", 16'h0000, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, tbl1[i].req, tbl1[i].done);
            checkRr($sformatf("tbl1[%0d]", i), tbl1[i].expGnt, tbl1[i].expIdx,
                    tbl1[i].expValid, tbl1[i].expPre);
        end
        checkFix("fix_idle", 16'h0000, 4'd0, 1'b0, 1'b0);

        applyStimulus(1'b0, 16'hFFFF, 1'b0);
        checkRr("grant_before_rst", 16'h4000, 4'd14, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkRr("async_rst", 16'h0000, 4'd0, 1'b0, 1'b0);
        busRr.Req  = '0;
        busRr.Done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkRr("idle_after_rst", 16'h0000, 4'd0, 1'b0, 1'b0);

        for (int k = 0; k < 17; k++) begin
            applyStimulus(1'b0, tbl2[k].req, tbl2[k].done);
            checkRr($sformatf("tbl2[%0d]", k), tbl2[k].expGnt, tbl2[k].expIdx,
                    tbl2[k].expValid, tbl2[k].expPre);
        end

        applyStimulus(1'b0, 16'h0011, 1'b0);
        checkRr("hold_start", 16'h0010, 4'd4, 1'b1, 1'b0);
        for (int j = 1; j < 16; j++) begin
            applyStimulus(1'b0, 16'h0011, 1'b0);
            checkRr($sformatf("hold_%0d", j), 16'h0010, 4'd4, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 16'h0011, 1'b0);
        checkRr("preempt", 16'h0001, 4'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'h0011, 1'b0);
        checkRr("preempt_pulse_end", 16'h0001, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0010, 1'b0);
        checkRr("owner4_back", 16'h0010, 4'd4, 1'b1, 1'b0);
        for (int j = 0; j < 40; j++) begin
            applyStimulus(1'b0, 16'h0010, 1'b0);
            checkRr($sformatf("hold_alone_%0d", j), 16'h0010, 4'd4, 1'b1, 1'b0);
        end

        for (int j = 0; j < 6; j++) begin
            applyStimulus(1'b1, 16'h00FF, 1'b1);
            checkFix($sformatf("fix_done_%0d", j), 16'h0080, 4'd7, 1'b1, 1'b0);
        end
        for (int j = 1; j < 16; j++) begin
            applyStimulus(1'b1, 16'h00FF, 1'b0);
            checkFix($sformatf("fix_hold_%0d", j), 16'h0080, 4'd7, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 16'h00FF, 1'b0);
        checkFix("fix_preempt", 16'h0040, 4'd6, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h00FF, 1'b0);
        checkFix("fix_after_preempt", 16'h0040, 4'd6, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
